// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store unit. Decodes RV32I loads and stores from the EX/MEM pipeline register,
// issues one word-addressed request/acknowledge transaction per access to a multi-cycle data
// memory, freezes the pipeline while that access is outstanding and returns the aligned,
// sign- or zero-extended load result to the writeback path.
//
// Build option:
//   MEM_TIMEOUT_EN  When defined, an outstanding request is abandoned after TIMEOUT cycles
//                   without acknowledge; the load result is forced to 0 and bus_err is set
//                   until reset. When undefined, a request waits indefinitely and bus_err is 0.
//
// Parameters:
//   ADDR_W   word-address width presented to the memory (byte address bits [ADDR_W+1:2])
//   TIMEOUT  acknowledge wait limit in REQ cycles (MEM_TIMEOUT_EN builds only)
//
// Ports:
//   clk, rstn      clock (rising edge) and asynchronous active-low reset
//   ir_MEM         instruction in MEM stage (opcode [6:0], funct3 [14:12])
//   alu_y_MEM      effective byte address
//   wd_MEM         store data (rs2 value)
//   ext_stall      stall from other pipeline sources; keeps a finished access in DONE
//   stall          freeze request for IF..MEM
//   rd_data        load result for MEM/WB
//   mem_req        request, held until acknowledge
//   mem_we         1 = write
//   mem_addr       word address
//   mem_wdata      lane-replicated write data
//   mem_wstrb      byte enables, 0 for reads
//   mem_rdata      read data, valid with mem_ack
//   mem_ack        single-cycle acknowledge
//   misalign_err   sticky misaligned-access flag
//   bus_err        sticky timeout flag
// ---------------------------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       ir_MEM,
    input  logic [31:0]       alu_y_MEM,
    input  logic [31:0]       wd_MEM,
    input  logic              ext_stall,
    output logic              stall,
    output logic [31:0]       rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    // Decode of the instruction currently in MEM
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [1:0]  w_off;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_valid;
    logic        w_misalign;
    logic        w_access;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    // Access state captured at issue; the pipeline is frozen, but the extraction does not
    // rely on that.
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_mem_wdata;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_off;
    logic              r_is_load;
    logic [31:0]       r_rd_data;
    logic              r_misalign;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic        w_stall;
    logic        w_timeout;
    logic        w_unused;

    assign w_opcode = ir_MEM[6:0];
    assign w_funct3 = ir_MEM[14:12];
    assign w_off    = alu_y_MEM[1:0];

    // -----------------------------------------------------------------------------------------
    // Decode and alignment
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        if (w_opcode == OpLoad) begin
            case (w_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_is_load = 1'b1;
                default:                                w_is_load = 1'b0;
            endcase
        end
        if (w_opcode == OpStore) begin
            case (w_funct3)
                3'b000, 3'b001, 3'b010: w_is_store = 1'b1;
                default:                w_is_store = 1'b0;
            endcase
        end
        // funct3[1:0] encodes the access size for every valid load/store
        case (w_funct3[1:0])
            2'b01:   w_misalign = w_off[0];
            2'b10:   w_misalign = (w_off != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_valid  = w_is_load | w_is_store;
    assign w_access = w_valid & ~w_misalign;

    // -----------------------------------------------------------------------------------------
    // Store lane steering
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0000_0000;
        if (w_is_store) begin
            case (w_funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << w_off;
                    w_wdata = {4{wd_MEM[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {w_off[1], 1'b0};
                    w_wdata = {2{wd_MEM[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = wd_MEM;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Load extraction from the acknowledged word
    // -----------------------------------------------------------------------------------------
    always_comb begin
        case (r_ld_off)
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_ld_funct3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_val = {24'h00_0000, w_byte};
            3'b101:  w_load_val = {16'h0000, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Optional acknowledge timeout
    // -----------------------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_inc;
    logic            r_bus_err;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Abort on the REQ cycle whose unacknowledged count would reach TIMEOUT
    assign w_timeout = (r_state == StReq) && !mem_ack && (w_cnt_inc == TimeoutVal);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == StIdle) begin
                r_cnt <= '0;
            end else if ((r_state == StReq) && !mem_ack) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err  = r_bus_err;
    assign w_unused = ^{ir_MEM[31:15], ir_MEM[11:7], alu_y_MEM};
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
    assign w_unused  = ^{ir_MEM[31:15], ir_MEM[11:7], alu_y_MEM, (TIMEOUT == 0)};
`endif

    // -----------------------------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                w_stall = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                // The finished instruction is still in MEM while ext_stall holds; waiting
                // here keeps it from being issued a second time.
                if (!ext_stall) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Request, result and error registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_ld_funct3 <= 3'b000;
            r_ld_off    <= 2'b00;
            r_is_load   <= 1'b0;
            r_rd_data   <= 32'h0000_0000;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_access) begin
                        r_mem_addr  <= alu_y_MEM[ADDR_W+1:2];
                        r_mem_we    <= w_is_store;
                        r_mem_wstrb <= w_wstrb;
                        r_mem_wdata <= w_wdata;
                        r_ld_funct3 <= w_funct3;
                        r_ld_off    <= w_off;
                        r_is_load   <= w_is_load;
                    end else if (w_valid) begin
                        // Misaligned: access suppressed, result cleared, flag latched
                        r_rd_data  <= 32'h0000_0000;
                        r_misalign <= 1'b1;
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        if (r_is_load) begin
                            r_rd_data <= w_load_val;
                        end
                    end else if (w_timeout) begin
                        r_rd_data <= 32'h0000_0000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall        = w_stall;
    assign mem_req      = (r_state == StReq);
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wstrb    = r_mem_wstrb;
    assign rd_data      = r_rd_data;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int AW = 8;
    localparam int TO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic          clk = 1'b0;
    logic          rstn;
    logic [31:0]   ir_MEM;
    logic [31:0]   alu_y_MEM;
    logic [31:0]   wd_MEM;
    logic          ext_stall;
    logic          stall;
    logic [31:0]   rd_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic          misalign_err;
    logic          bus_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: byte-addressed memory plus expected sticky/result values
    logic [7:0]  ref_mem [0:1023];
    // Memory device seen by the DUT (word array written through strobes)
    logic [31:0] dev_mem [0:255];
    logic [31:0] exp_rd  = 32'h0;
    logic        exp_mis = 1'b0;
    logic        exp_bus = 1'b0;

    logic [2:0] ld_ok  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] ld_bad [3] = '{3'd3, 3'd6, 3'd7};

    mem_access_unit #(
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ir_MEM      (ir_MEM),
        .alu_y_MEM   (alu_y_MEM),
        .wd_MEM      (wd_MEM),
        .ext_stall   (ext_stall),
        .stall       (stall),
        .rd_data     (rd_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .misalign_err(misalign_err),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = opc;
        r[14:12] = f3;
        return r;
    endfunction

    task automatic set_word(input int w, input logic [31:0] val);
        dev_mem[w] = val;
        for (int i = 0; i < 4; i++) ref_mem[4*w+i] = val[8*i +: 8];
    endtask

    // Little-endian read of n bytes, then signed wrap if requested
    function automatic logic [31:0] ref_load(input int a, input int n, input bit sgn);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a+i]) << (8*i);
        if (sgn && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    task automatic ref_store(input int a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
    endtask

    // delay = REQ cycle (1-based) on which mem_ack is given; 0 = never
    task automatic run_op(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input string tag);
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          is_ld, is_st, mis, sgn, done;
        int          n, nstall, nreq, exp_req;
        logic [31:0] s_addr, s_wdata, exp_wdata;
        logic        s_we;
        logic [3:0]  s_wstrb;
        int          exp_wstrb;
        opc = ir[6:0];
        f3 = ir[14:12];
        is_ld = (opc == LD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        is_st = (opc == ST) && (f3 <= 3'd2);
        n = 1 << f3[1:0];
        sgn = (f3[2] == 1'b0);
        mis = (is_ld || is_st) && ((addr % n) != 0);
        s_addr = 0; s_wdata = 0; s_we = 0; s_wstrb = 0; exp_wdata = 0;
        @(negedge clk);
        ir_MEM = ir; alu_y_MEM = addr; wd_MEM = wd; mem_ack = 1'b0;
        #1;
        nstall = 0; nreq = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                mem_ack = 1'b0;
                #1;
            end
            if (stall) nstall++;
            else done = 1;
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    s_addr = 32'(mem_addr); s_we = mem_we; s_wstrb = mem_wstrb; s_wdata = mem_wdata;
                end
                if (nreq == delay) begin
                    mem_rdata = dev_mem[mem_addr];
                    mem_ack = 1'b1;
                    if (mem_we)
                        for (int j = 0; j < 4; j++)
                            if (mem_wstrb[j]) dev_mem[mem_addr][8*j +: 8] = mem_wdata[8*j +: 8];
                end
            end
        end
        check($sformatf("%s.done", tag), 32'(done), 32'd1);
        @(posedge clk);
        #1;
        ir_MEM = NOP; alu_y_MEM = 32'h0;
        if ((is_ld || is_st) && !mis) begin
            exp_req = (delay == 0) ? TO : delay;
            check($sformatf("%s.addr", tag), s_addr, (addr >> 2) & ((32'd1 << AW) - 1));
            check($sformatf("%s.we", tag), 32'(s_we), 32'(is_st));
            if (is_st) begin
                exp_wstrb = ((1 << n) - 1) << (addr % 4);
                for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wd[8*(j % n) +: 8];
                check($sformatf("%s.wstrb", tag), 32'(s_wstrb), 32'(exp_wstrb));
                check($sformatf("%s.wdata", tag), s_wdata, exp_wdata);
            end else begin
                check($sformatf("%s.wstrb", tag), 32'(s_wstrb), 32'd0);
            end
            if (delay == 0) begin
                exp_rd = 32'h0;
                exp_bus = 1'b1;
            end else if (is_ld) begin
                exp_rd = ref_load(int'(addr), n, sgn);
            end else begin
                ref_store(int'(addr), n, wd);
            end
        end else begin
            exp_req = 0;
            if (is_ld || is_st) begin
                exp_rd = 32'h0;
                exp_mis = 1'b1;
            end
        end
        check($sformatf("%s.stall_cycles", tag), 32'(nstall), 32'(exp_req == 0 ? 0 : exp_req + 1));
        check($sformatf("%s.req_cycles", tag), 32'(nreq), 32'(exp_req));
        check($sformatf("%s.rd_data", tag), rd_data, exp_rd);
        check($sformatf("%s.misalign", tag), 32'(misalign_err), 32'(exp_mis));
        check($sformatf("%s.bus_err", tag), 32'(bus_err), 32'(exp_bus));
    endtask

    initial begin
        logic [31:0] ir, a;
        logic [2:0]  f3;
        int          r, n;

        for (int w = 0; w < 256; w++) set_word(w, $urandom);
        rstn = 1'b0; ir_MEM = NOP; alu_y_MEM = 0; wd_MEM = 0; ext_stall = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.mem_req", 32'(mem_req), 32'd0);
        check("reset.mem_we", 32'(mem_we), 32'd0);
        check("reset.mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("reset.mem_addr", 32'(mem_addr), 32'd0);
        check("reset.mem_wdata", mem_wdata, 32'd0);
        check("reset.rd_data", rd_data, 32'd0);
        check("reset.misalign", 32'(misalign_err), 32'd0);
        check("reset.bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // lw 0x10, ack on third REQ cycle
        set_word(4, 32'hDEAD_BEEF);
        run_op(mk(LD, 3'b010), 32'h10, 32'h0, 3, "lw_10");
        check("lw_10.lit", rd_data, 32'hDEAD_BEEF);

        // sb 0x13, ack on first REQ cycle
        run_op(mk(ST, 3'b000), 32'h13, 32'h0000_00A5, 1, "sb_13");
        check("sb_13.lit_wstrb", 32'(mem_wstrb), 32'h8);
        check("sb_13.lit_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_13.lit_we", 32'(mem_we), 32'd1);

        // lb / lhu lane extraction
        set_word(8, 32'h80FF_7F01);
        run_op(mk(LD, 3'b000), 32'h21, 32'h0, 2, "lb_21");
        check("lb_21.lit", rd_data, 32'h0000_007F);
        run_op(mk(LD, 3'b101), 32'h22, 32'h0, 1, "lhu_22");
        check("lhu_22.lit", rd_data, 32'h0000_80FF);

        // Randomized mix of loads, stores and non-memory encodings
        for (int k = 0; k < 48; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                f3 = ld_ok[$urandom_range(0, 4)];
                ir = mk(LD, f3);
            end else if (r <= 8) begin
                f3 = 3'($urandom_range(0, 2));
                ir = mk(ST, f3);
            end else begin
                f3 = 3'($urandom_range(3, 7));
                case ($urandom_range(0, 2))
                    0:       ir = mk(LD, ld_bad[$urandom_range(0, 2)]);
                    1:       ir = mk(ST, f3);
                    default: ir = mk(7'b0110011, f3);
                endcase
            end
            n = 1 << ir[13:12];
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) != 0) a = a & ~32'(n - 1);
            run_op(ir, a, $urandom, $urandom_range(1, 3), $sformatf("rnd%0d", k));
        end

        // ext_stall holds DONE: no re-issue, stall low, stray acks ignored
        set_word(16, 32'h1234_5678);
        @(negedge clk);
        ir_MEM = mk(LD, 3'b010); alu_y_MEM = 32'h40;
        #1;
        check("ext.idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check("ext.req", 32'(mem_req), 32'd1);
        mem_rdata = dev_mem[16]; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; ext_stall = 1'b1;
        #1;
        check("ext.done_stall", 32'(stall), 32'd0);
        check("ext.done_req", 32'(mem_req), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ack = (c == 0); mem_rdata = 32'hEDCB_A987;
            #1;
            check($sformatf("ext.hold%0d_stall", c), 32'(stall), 32'd0);
            check($sformatf("ext.hold%0d_req", c), 32'(mem_req), 32'd0);
        end
        @(negedge clk);
        mem_ack = 1'b0; ext_stall = 1'b0;
        @(posedge clk);
        #1;
        ir_MEM = NOP;
        exp_rd = 32'h1234_5678;
        check("ext.rd_data", rd_data, exp_rd);
        check("ext.idle_req", 32'(mem_req), 32'd0);

        // Misaligned word load, then flag persists across a good store
        run_op(mk(LD, 3'b010), 32'h06, 32'h0, 1, "lw_06");
        check("lw_06.lit_mis", 32'(misalign_err), 32'd1);
        check("lw_06.lit_rd", rd_data, 32'd0);
        run_op(mk(ST, 3'b010), 32'h30, $urandom | 32'h1, 2, "sw_30");

`ifdef MEM_TIMEOUT_EN
        run_op(mk(LD, 3'b010), 32'h50, 32'h0, 0, "timeout");
        check("timeout.lit_bus", 32'(bus_err), 32'd1);
        check("timeout.lit_rd", rd_data, 32'd0);
`endif

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        ir_MEM = mk(LD, 3'b010); alu_y_MEM = 32'h84;
        #1;
        @(negedge clk);
        #1;
        check("rst.req_before", 32'(mem_req), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst.mem_addr", 32'(mem_addr), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.rd_data", rd_data, 32'd0);
        check("rst.misalign", 32'(misalign_err), 32'd0);
        check("rst.bus_err", 32'(bus_err), 32'd0);
        ir_MEM = NOP;
        #1;
        check("rst.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_rd = 32'h0; exp_mis = 1'b0; exp_bus = 1'b0;

        // Normal operation resumes after reset
        run_op(mk(LD, 3'b001), 32'h86, 32'h0, 2, "post_rst_lh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
